// File: rtl/irq_arbiter.sv
// irq_arbiter: latches interrupt edges, arbitrates by priority and enable, and hands one vector at a time to the core.
// Preempted levels are kept on a stack and restored on irq_done.
module irq_arbiter #(
  parameter int VecAmount = 8,
  parameter int PrioWidth = 3,
  parameter int StackDepth = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [VecAmount-1:0]         src_level,
  output logic [VecAmount-1:0]         src_clear,
  input  logic                         cfg_we,
  input  logic [$clog2(VecAmount)-1:0] cfg_index,
  input  logic                         cfg_enable,
  input  logic [PrioWidth-1:0]         cfg_prio,
  output logic                         irq_req,
  output logic [$clog2(VecAmount)-1:0] irq_id,
  output logic [PrioWidth-1:0]         irq_prio,
  input  logic                         irq_ack,
  input  logic                         irq_done,
  output logic [PrioWidth-1:0]         cur_level,
  output logic                         stack_full
);
  localparam int IdW = $clog2(VecAmount);
  localparam int SpW = $clog2(StackDepth + 1);
  localparam int StW = (StackDepth > 1) ? $clog2(StackDepth) : 1;
  logic [VecAmount-1:0] src_q, pending, enable, rise, clr, elig, pending_nxt;
  logic [VecAmount-1:0][PrioWidth-1:0] prio;
  logic [StackDepth-1:0][PrioWidth-1:0] stack;
  logic [SpW-1:0] sp, sp_done, sp_nxt;
  logic [PrioWidth-1:0] lvl_done, lvl_nxt, best_prio;
  logic [IdW-1:0] best_id;
  logic take, req_nxt;
  assign take = irq_ack & irq_req;
  assign rise = src_level & ~src_q;
  assign clr = take ? VecAmount'(1) << irq_id : '0;
  assign pending_nxt = (pending & ~clr) | rise;
  assign stack_full = sp == SpW'(StackDepth);
  // done pops first, then an ack pushes the level that the pop produced
  always_comb begin
    sp_done = (irq_done && sp != '0) ? sp - 1'b1 : sp;
    lvl_done = irq_done ? (sp != '0 ? stack[StW'(sp - 1'b1)] : '0) : cur_level;
    sp_nxt = take ? sp_done + 1'b1 : sp_done;
    lvl_nxt = take ? irq_prio : lvl_done;
  end
  // downward scan with >= lets the lowest index win ties
  always_comb begin
    elig = '0;
    best_id = '0;
    best_prio = '0;
    for (int i = VecAmount - 1; i >= 0; i--) begin
      elig[i] = pending[i] & enable[i] & (prio[i] > lvl_nxt);
      if (elig[i] && prio[i] >= best_prio) begin
        best_id = IdW'(i);
        best_prio = prio[i];
      end
    end
    req_nxt = |elig && !take && sp_nxt != SpW'(StackDepth);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      src_q <= '0;
      pending <= '0;
      enable <= '0;
      prio <= '0;
      stack <= '0;
      sp <= '0;
      cur_level <= '0;
      src_clear <= '0;
      irq_req <= 1'b0;
      irq_id <= '0;
      irq_prio <= '0;
    end else begin
      src_q <= src_level;
      pending <= pending_nxt;
      if (cfg_we) begin
        enable[cfg_index] <= cfg_enable;
        prio[cfg_index] <= cfg_prio;
      end
      if (take) stack[StW'(sp_done)] <= lvl_done;
      sp <= sp_nxt;
      cur_level <= lvl_nxt;
      src_clear <= clr;
      irq_req <= req_nxt;
      irq_id <= best_id;
      irq_prio <= best_prio;
    end
endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Consumes `interrupt_set` levels from the timer and other peripheral interrupt sources.
- Latches per-vector pending bits, applies per-vector enable and priority, and arbitrates the highest-priority eligible vector.
- Presents that vector to the core through a registered req/ack handshake.
- Keeps a preemption-level stack so nested interrupts return to the correct level on `irq_done`.
- Drives `interrupt_clear` pulses back to each source when that source's vector is taken.

Parameters:
VecAmount, 8, number of interrupt vectors (vector i = source i)
PrioWidth, 3, priority bits; priority 0 means never interrupts
StackDepth, 4, maximum nesting depth of preempted levels

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
src_level  in  VecAmount  interrupt_set lines from sources (level, held until cleared)
src_clear  out  VecAmount  one-cycle interrupt_clear pulse per source
cfg_we  in  1  configuration write strobe
cfg_index  in  $clog2(VecAmount)  vector being configured
cfg_enable  in  1  enable bit to write
cfg_prio  in  PrioWidth  priority to write
irq_req  out  1  request to core
irq_id  out  $clog2(VecAmount)  vector of current request
irq_prio  out  PrioWidth  priority of current request
irq_ack  in  1  core takes the request (sampled only while irq_req=1)
irq_done  in  1  core returns from handler (mret), one-cycle pulse
cur_level  out  PrioWidth  current running priority level (0 = thread mode)
stack_full  out  1  nesting stack holds StackDepth entries

Behaviour:
- Reset (reset=0, async) clears all of the following:
  - pending, enable, prio, previous-level sample registers
  - the stack and stack pointer
  - cur_level, irq_req, irq_id, irq_prio, src_clear
- Pending set: on a rising edge of src_level[i], pending[i] <= 1 on the next clk.
  - A level held high without an edge does not re-set pending.
- Pending clear: the ack of vector i sets pending[i] <= 0 and src_clear[i] = 1 for exactly one cycle, in the cycle after the ack.
  - If a new rising edge of src_level[i] arrives in the same cycle as the clear, the set wins and pending[i] stays 1.
- Eligibility: vector i is eligible when pending[i] & enable[i] & (prio[i] > cur_level).
- Arbitration:
  - The highest prio wins; ties go to the lowest index.
  - The result is registered into irq_req/irq_id/irq_prio every cycle.
  - Latency from src_level edge to irq_req = 2 cycles.
- irq_req is forced to 0 while stack_full=1; no preemption beyond StackDepth.
- Handshake:
  - irq_ack is honoured only while irq_req=1.
  - On ack: push cur_level, set cur_level <= irq_prio, clear the pending bit as above.
  - irq_req drops the cycle after ack and is re-evaluated against the new level.
- irq_done: pop the stack into cur_level.
  - irq_done with an empty stack sets cur_level to 0 and is otherwise ignored.
- Simultaneous irq_ack and irq_done: the done is processed first (pop), then the ack (push). The net effect is a replace with unchanged depth, and cur_level <= irq_prio.
- Config writes take effect the next cycle.
  - Disabling a vector keeps its pending bit.
  - A write to the vector currently presented updates arbitration the following cycle; the req may drop.
- Priority values compare unsigned; no wrap.

State machine, per stack depth: IDLE (depth 0) -> NESTED(d) on ack; NESTED(d) -> NESTED(d-1) on done; FULL at d = StackDepth.

Test Plan:
- prio[3]=5, en[3]=1, src_level[3] 0->1 at cycle 10 -> irq_req=1, irq_id=3, irq_prio=5 at cycle 12; ack at 13 -> src_clear[3]=1 at 14 only, cur_level=5, irq_req=0.
- Vectors 2 (prio 4) and 6 (prio 4) set together -> irq_id=2 first; after ack, cur_level=4 so vector 6 is blocked; irq_done -> cur_level=0, irq_id=6 presented.
- Nesting: take prio 2, then prio 5 preempts, then prio 7 preempts -> cur_level 2,5,7; three irq_done pulses -> 5,2,0.
- StackDepth=4 with four nested acks -> stack_full=1; a pending prio-7 vector gives irq_req=0 until one irq_done.
- Rising edge on src_level[1] in the same cycle its ack clear occurs -> pending[1] stays 1 and is re-requested after cur_level drops.
- Assert reset=0 asynchronously mid-nesting (cur_level=5) -> all outputs 0 immediately with no clk edge; after release, no request until a new src edge.
